// File: rtl/led_pwm_ctrl_pkg.sv
// Shared constants, response FSM states and frame helpers for the LED PWM command sink.
// Imported by every file of led_pwm_ctrl.
package led_pwm_ctrl_pkg;

    localparam int unsigned CMD_BITS           = 8;
    localparam int unsigned ADDR_BITS          = 8;
    localparam int unsigned PAYLOAD_BITS       = 8;
    localparam int unsigned MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    localparam logic [CMD_BITS-1:0] CMD_NOP   = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h02;
    localparam logic [CMD_BITS-1:0] CMD_ERR   = 8'hEE;

    localparam logic [ADDR_BITS-1:0]    ADDR_NONE    = 8'h00;
    localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_NONE = 8'hFF;
    localparam logic [PAYLOAD_BITS-1:0] DUTY_MAX     = 8'd100;
    localparam logic [ADDR_BITS-1:0]    ERR_ADDR     = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StActive
    } resp_state_e;

    function automatic logic [PAYLOAD_BITS-1:0] clamp_duty(input logic [PAYLOAD_BITS-1:0] pct);
        return (pct > DUTY_MAX) ? DUTY_MAX : pct;
    endfunction

    function automatic logic [MASTER_FRAME_WIDTH-1:0] pack_frame(
        input logic [CMD_BITS-1:0]     cmd,
        input logic [ADDR_BITS-1:0]    addr,
        input logic [PAYLOAD_BITS-1:0] payload
    );
        return {cmd, addr, payload};
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Decoded-frame and response bus between the SPI slave (master modport) and
// led_pwm_ctrl (slave modport).
interface led_pwm_ctrl_if;
    import led_pwm_ctrl_pkg::*;

    logic                          frm_vld;
    logic [CMD_BITS-1:0]           i_cmd;
    logic [ADDR_BITS-1:0]          i_addr;
    logic [PAYLOAD_BITS-1:0]       i_payload;
    logic                          cs;
    logic                          o_slv_tx_enb;
    logic [MASTER_FRAME_WIDTH-1:0] o_slv_frame;
    logic                          o_err;

    modport master (
        output frm_vld, i_cmd, i_addr, i_payload, cs,
        input  o_slv_tx_enb, o_slv_frame, o_err
    );

    modport slave (
        input  frm_vld, i_cmd, i_addr, i_payload, cs,
        output o_slv_tx_enb, o_slv_frame, o_err
    );

endinterface

// File: rtl/led_pwm_ctrl_pwm_channel.sv
// One PWM output: the target duty is taken only at the period wrap so a change never
// produces a truncated or stretched pulse inside a period.
module led_pwm_ctrl_pwm_channel
    import led_pwm_ctrl_pkg::*;
(
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic [PAYLOAD_BITS-1:0] step,
    input  logic                    wrap,
    input  logic [PAYLOAD_BITS-1:0] duty_target,
    output logic                    led
);

    logic [PAYLOAD_BITS-1:0] duty_active_q;
    logic                    led_q;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            duty_active_q <= '0;
            led_q         <= 1'b0;
        end else begin
            if (wrap) begin
                duty_active_q <= duty_target;
            end
            led_q <= (step < duty_active_q);
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Command sink behind the SPI slave: per-LED brightness registers, shared PWM timebase and
// the read-response FSM. Optional error counter at address 8'hFF under `LED_ERR_CNT_EN.
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 4,
    parameter int unsigned PWM_STEPS = 100,
    parameter int unsigned PRESCALE  = 1250
) (
    input  logic                sysclk,
    input  logic                rst,
    led_pwm_ctrl_if.slave       bus,
    output logic [NUM_LEDS-1:0] o_led
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // PWM timebase
    logic [PreW-1:0]         pre_q;
    logic [PAYLOAD_BITS-1:0] step_q;
    logic                    pre_wrap;
    logic                    step_wrap;

    assign pre_wrap  = (pre_q == PreW'(PRESCALE - 1));
    assign step_wrap = pre_wrap && (step_q == PAYLOAD_BITS'(PWM_STEPS - 1));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            pre_q  <= '0;
            step_q <= '0;
        end else begin
            pre_q <= pre_wrap ? '0 : pre_q + PreW'(1);
            if (pre_wrap) begin
                step_q <= step_wrap ? '0 : step_q + PAYLOAD_BITS'(1);
            end
        end
    end

    // Frame decode
    logic [PAYLOAD_BITS-1:0]       duty_target_q [NUM_LEDS];
    logic [PAYLOAD_BITS-1:0]       duty_target_d [NUM_LEDS];
    logic [PAYLOAD_BITS-1:0]       rd_duty;
    logic                          addr_ok;
    logic                          rd_hit;
    logic                          err_d;
    logic                          err_q;
    logic [MASTER_FRAME_WIDTH-1:0] resp;

`ifdef LED_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_addr;
    logic       cnt_clr;
`endif

    always_comb begin
        duty_target_d = duty_target_q;
        rd_duty       = '0;
        addr_ok       = 1'b0;
        rd_hit        = 1'b0;
        err_d         = 1'b0;
        resp          = '0;
`ifdef LED_ERR_CNT_EN
        err_addr      = (bus.i_addr == ERR_ADDR);
        cnt_clr       = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (bus.i_addr == ADDR_BITS'(i)) begin
                addr_ok = 1'b1;
                rd_duty = duty_target_q[i];
            end
        end

        if (bus.frm_vld) begin
            case (bus.i_cmd)
                CMD_NOP: ;
                CMD_WRITE: begin
                    if (addr_ok) begin
                        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                            if (bus.i_addr == ADDR_BITS'(i)) begin
                                duty_target_d[i] = clamp_duty(bus.i_payload);
                            end
                        end
                    end
`ifdef LED_ERR_CNT_EN
                    else if (err_addr) begin
                        cnt_clr = 1'b1;
                    end
`endif
                    else begin
                        err_d = 1'b1;
                    end
                end
                CMD_READ: begin
                    rd_hit = 1'b1;
                    if (addr_ok) begin
                        resp = pack_frame(CMD_READ, bus.i_addr, rd_duty);
                    end
`ifdef LED_ERR_CNT_EN
                    else if (err_addr) begin
                        resp = pack_frame(CMD_READ, ERR_ADDR, err_cnt_q);
                    end
`endif
                    else begin
                        resp  = pack_frame(CMD_ERR, bus.i_addr, PAYLOAD_NONE);
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

`ifdef LED_ERR_CNT_EN
    always_ff @(posedge sysclk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (cnt_clr) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`endif

    // Response FSM
    resp_state_e                   state_q, state_d;
    logic [MASTER_FRAME_WIDTH-1:0] frame_q, frame_d;
    logic [MASTER_FRAME_WIDTH-1:0] pend_frame_q, pend_frame_d;
    logic                          pend_vld_q, pend_vld_d;
    logic                          cs_q;
    logic                          cs_fall;
    logic                          cs_rise;

    assign cs_fall = (cs_q == CS_DEASSERT) && (bus.cs == CS_ASSERT);
    assign cs_rise = (cs_q == CS_ASSERT) && (bus.cs == CS_DEASSERT);

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        pend_frame_d = pend_frame_q;
        pend_vld_d   = pend_vld_q;
        unique case (state_q)
            StIdle: begin
                if (rd_hit) begin
                    frame_d = resp;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (rd_hit) begin
                    frame_d = resp;
                end
                if (cs_fall) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                // The shifting frame must not change; park new reads until cs releases.
                if (rd_hit) begin
                    pend_vld_d   = 1'b1;
                    pend_frame_d = resp;
                end
                if (cs_rise) begin
                    if (pend_vld_d) begin
                        frame_d    = pend_frame_d;
                        pend_vld_d = 1'b0;
                        state_d    = StArm;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= StIdle;
            frame_q      <= pack_frame(CMD_NOP, ADDR_NONE, '0);
            pend_frame_q <= '0;
            pend_vld_q   <= 1'b0;
            cs_q         <= CS_DEASSERT;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty_target_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            pend_frame_q  <= pend_frame_d;
            pend_vld_q    <= pend_vld_d;
            cs_q          <= bus.cs;
            err_q         <= err_d;
            duty_target_q <= duty_target_d;
        end
    end

    assign bus.o_slv_tx_enb = (state_q != StIdle);
    assign bus.o_slv_frame  = frame_q;
    assign bus.o_err        = err_q;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_ctrl_pwm_channel u_pwm_channel (
            .sysclk      (sysclk),
            .rst         (rst),
            .step        (step_q),
            .wrap        (step_wrap),
            .duty_target (duty_target_q[g]),
            .led         (o_led[g])
        );
    end

endmodule
